// File: rtl/vga_pkg.sv
// Shared definitions for the rectangle-fill accelerator: the bus register
// offsets, FSM state encoding, frame geometry and the {y,x} frame-buffer
// address packing used by both the top level and the raster scanner.
package vga_pkg;

  localparam int FRAME_W = 160;
  localparam int FRAME_H = 120;
  localparam int FB_AW   = 15;

  // Offsets from BASE_ADDR of the six bus registers.
  localparam logic [2:0] OFF_X0     = 3'd0;
  localparam logic [2:0] OFF_Y0     = 3'd1;
  localparam logic [2:0] OFF_X1     = 3'd2;
  localparam logic [2:0] OFF_Y1     = 3'd3;
  localparam logic [2:0] OFF_START  = 3'd4;
  localparam logic [2:0] OFF_STATUS = 3'd5;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } state_e;

  // Frame-buffer address: row in the upper 7 bits, column in the lower 8.
  function automatic logic [FB_AW-1:0] fb_pack(input logic [6:0] y,
                                               input logic [7:0] x);
    return {y, x};
  endfunction

endpackage

// File: rtl/vga_rect_scanner.sv
// Raster scanner for one rectangle fill.
//   clk_i, rst_i   : clock, asynchronous active-high reset
//   load_i         : capture and normalise the corners, park on the top-left
//   step_i         : advance one pixel in raster order
//   xa_i/xb_i      : the two x corners (any order)
//   ya_i/yb_i      : the two y corners (any order)
//   cx_o/cy_o      : current pixel coordinate
//   last_o         : current pixel is the bottom-right corner
// The working corners are private copies, so later writes to the bus-side
// corner registers cannot disturb a fill that is already running.
module vga_rect_scanner (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       load_i,
  input  logic       step_i,
  input  logic [7:0] xa_i,
  input  logic [7:0] xb_i,
  input  logic [6:0] ya_i,
  input  logic [6:0] yb_i,
  output logic [7:0] cx_o,
  output logic [6:0] cy_o,
  output logic       last_o
);

  logic [7:0] xl_q, xl_d, xh_q, xh_d, cx_q, cx_d;
  logic [6:0] yl_q, yl_d, yh_q, yh_d, cy_q, cy_d;

  assign last_o = (cx_q == xh_q) && (cy_q == yh_q);
  assign cx_o   = cx_q;
  assign cy_o   = cy_q;

  always_comb begin
    xl_d = xl_q;
    xh_d = xh_q;
    yl_d = yl_q;
    yh_d = yh_q;
    cx_d = cx_q;
    cy_d = cy_q;
    if (load_i) begin
      xl_d = (xa_i < xb_i) ? xa_i : xb_i;
      xh_d = (xa_i < xb_i) ? xb_i : xa_i;
      yl_d = (ya_i < yb_i) ? ya_i : yb_i;
      yh_d = (ya_i < yb_i) ? yb_i : ya_i;
      cx_d = xl_d;
      cy_d = yl_d;
    end else if (step_i && !last_o) begin
      if (cx_q < xh_q) begin
        cx_d = cx_q + 8'd1;
      end else begin
        // End of a row: wrap back to the left edge of the next row.
        cx_d = xl_q;
        cy_d = cy_q + 7'd1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      xl_q <= '0;
      xh_q <= '0;
      yl_q <= '0;
      yh_q <= '0;
      cx_q <= '0;
      cy_q <= '0;
    end else begin
      xl_q <= xl_d;
      xh_q <= xh_d;
      yl_q <= yl_d;
      yh_q <= yh_d;
      cx_q <= cx_d;
      cy_q <= cy_d;
    end
  end

endmodule

// File: rtl/vga_rect_fill.sv
// Bus-mapped rectangle-fill accelerator for the VGA frame buffer.
//   CLK, RESET : system clock, asynchronous active-high reset
//   BUS_DATA   : shared bidirectional data bus (driven only for STATUS reads)
//   BUS_ADDR   : shared address bus; BASE_ADDR..BASE_ADDR+5 belong to us
//   BUS_WE     : shared write enable
//   FB_ADDR    : frame-buffer address {y[6:0], x[7:0]}
//   FB_DATA    : pixel bit being written
//   FB_WE      : frame-buffer write strobe, one pixel per cycle
//   BUSY       : a fill is in progress
// Register map: X0, Y0, X1, Y1, START (data[0] = pixel), STATUS {DONE, BUSY}.
module vga_rect_fill
  import vga_pkg::*;
#(
  parameter logic [7:0] BASE_ADDR = 8'hB8,
  parameter int         X_MAX     = FRAME_W - 1,
  parameter int         Y_MAX     = FRAME_H - 1
) (
  input  logic             CLK,
  input  logic             RESET,
  inout  wire  [7:0]       BUS_DATA,
  input  logic [7:0]       BUS_ADDR,
  input  logic             BUS_WE,
  output logic [FB_AW-1:0] FB_ADDR,
  output logic             FB_DATA,
  output logic             FB_WE,
  output logic             BUSY
);

  function automatic logic [7:0] clamp_x(input logic [7:0] v);
    return (v > 8'(X_MAX)) ? 8'(X_MAX) : v;
  endfunction

  // Bit 7 of a y write is dropped before clamping.
  function automatic logic [6:0] clamp_y(input logic [6:0] v);
    return (v > 7'(Y_MAX)) ? 7'(Y_MAX) : v;
  endfunction

  state_e           state_q, state_d;
  logic [7:0]       x0_q, x0_d, x1_q, x1_d;
  logic [6:0]       y0_q, y0_d, y1_q, y1_d;
  logic             pix_q, pix_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             fin_q, fin_d;
  logic             fb_we_q, fb_we_d;
  logic             fb_data_q, fb_data_d;
  logic [FB_AW-1:0] fb_addr_q, fb_addr_d;
  logic             rd_en_q, rd_en_d;

  logic [7:0] off;
  logic [2:0] off3;
  logic       in_range;
  logic       wr_hit;
  logic       start_acc;
  logic       load, step;
  logic [7:0] cx;
  logic [6:0] cy;
  logic       last;

  // Subtracting the base folds the range check into one compare and also
  // behaves correctly if the window sits near the top of the address space.
  assign off       = BUS_ADDR - BASE_ADDR;
  assign off3      = off[2:0];
  assign in_range  = off < 8'd6;
  assign wr_hit    = BUS_WE && in_range;
  assign start_acc = wr_hit && (off3 == OFF_START) && (state_q == IDLE);

  vga_rect_scanner u_scan (
    .clk_i  (CLK),
    .rst_i  (RESET),
    .load_i (load),
    .step_i (step),
    .xa_i   (x0_q),
    .xb_i   (x1_q),
    .ya_i   (y0_q),
    .yb_i   (y1_q),
    .cx_o   (cx),
    .cy_o   (cy),
    .last_o (last)
  );

  // Bus-side corner registers, clamped on the way in.
  always_comb begin
    x0_d = x0_q;
    y0_d = y0_q;
    x1_d = x1_q;
    y1_d = y1_q;
    if (wr_hit) begin
      case (off3)
        OFF_X0:  x0_d = clamp_x(BUS_DATA);
        OFF_Y0:  y0_d = clamp_y(BUS_DATA[6:0]);
        OFF_X1:  x1_d = clamp_x(BUS_DATA);
        OFF_Y1:  y1_d = clamp_y(BUS_DATA[6:0]);
        default: ;
      endcase
    end
  end

  // Fill FSM. fin_q marks that the last pixel has been issued; the state
  // after it retires the strobe and flips BUSY/DONE, which puts the BUSY
  // fall one edge after the last write.
  always_comb begin
    state_d   = state_q;
    busy_d    = busy_q;
    done_d    = done_q;
    fin_d     = fin_q;
    pix_d     = pix_q;
    fb_we_d   = 1'b0;
    fb_addr_d = fb_addr_q;
    fb_data_d = fb_data_q;
    load      = 1'b0;
    step      = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_acc) begin
          state_d = FILL;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          fin_d   = 1'b0;
          pix_d   = BUS_DATA[0];
          load    = 1'b1;
        end
      end
      FILL: begin
        if (fin_q) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          fb_we_d   = 1'b1;
          fb_addr_d = fb_pack(cy, cx);
          fb_data_d = pix_q;
          step      = 1'b1;
          fin_d     = last;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign rd_en_d = in_range && (off3 == OFF_STATUS) && !BUS_WE;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q   <= IDLE;
      x0_q      <= '0;
      y0_q      <= '0;
      x1_q      <= '0;
      y1_q      <= '0;
      pix_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      fin_q     <= 1'b0;
      fb_we_q   <= 1'b0;
      fb_data_q <= 1'b0;
      fb_addr_q <= '0;
      rd_en_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      x0_q      <= x0_d;
      y0_q      <= y0_d;
      x1_q      <= x1_d;
      y1_q      <= y1_d;
      pix_q     <= pix_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      fin_q     <= fin_d;
      fb_we_q   <= fb_we_d;
      fb_data_q <= fb_data_d;
      fb_addr_q <= fb_addr_d;
      rd_en_q   <= rd_en_d;
    end
  end

  // The read enable is registered, but gating with BUS_WE keeps us off the
  // bus on any write cycle even while the STATUS address is still held.
  assign BUS_DATA = (rd_en_q && !BUS_WE) ? {6'b0, done_q, busy_q} : 8'hzz;

  assign FB_ADDR = fb_addr_q;
  assign FB_DATA = fb_data_q;
  assign FB_WE   = fb_we_q;
  assign BUSY    = busy_q;

endmodule

// File: doc/vga_rect_fill.md
Name: vga_rect_fill

Overview:
- Memory-mapped bus peripheral that accelerates rectangle fills into the VGA frame buffer.
- The processor writes two corners and a pixel value, then starts the fill. The block streams one pixel write per clock in raster order on a frame-buffer write port.
- It is the upstream feeder of the VGA controller's frame-buffer write side; the top level muxes its port with the processor-driven pixel path while BUSY=1.
- Removes the three-bus-writes-per-pixel cost of software fills.

Parameters:
- BASE_ADDR, 8'hB8, first of six bus addresses owned by the block (BASE..BASE+5).
- X_MAX, 159, largest legal x coordinate (160-wide frame).
- Y_MAX, 119, largest legal y coordinate (120-high frame).

Ports:
- CLK  in  1  100MHz system clock.
- RESET  in  1  asynchronous, active-high reset.
- BUS_DATA  inout  8  shared data bus.
- BUS_ADDR  in  8  shared address bus.
- BUS_WE  in  1  shared write enable.
- FB_ADDR  out  15  frame-buffer address {y[6:0], x[7:0]}.
- FB_DATA  out  1  pixel bit to write.
- FB_WE  out  1  frame-buffer write strobe, one pixel per cycle.
- BUSY  out  1  high while a fill is in progress.

Behaviour:
- Reset: asynchronous and active-high, as decided. All of the following are cleared while RESET=1:
  - FB_ADDR=0, FB_DATA=0, FB_WE=0, BUSY=0, DONE=0.
  - Corner registers X0/Y0/X1/Y1 = 0; BUS_DATA released (Z); state=IDLE.
- Register map (writes sampled on the CLK edge when BUS_WE=1 and BUS_ADDR matches):
  - BASE+0 X0, BASE+1 Y0, BASE+2 X1, BASE+3 Y1.
  - BASE+4 START: data[0] = pixel value.
  - BASE+5 STATUS (read only): {6'b0, DONE, BUSY}.
- Coordinate clamping: at write time, x values > X_MAX are stored as X_MAX and y values > Y_MAX as Y_MAX. Y is 7 bits; data[7] of a y write is ignored before clamping.
- Read path: when BUS_ADDR==BASE+5 and BUS_WE=0, BUS_DATA is driven from the cycle after the address is sampled, for as long as the address is held. Otherwise BUS_DATA is Z. Never driven on a write cycle.
- Corner shadowing: on an accepted START, the corners are copied into working registers and normalised so xl=min(X0,X1), xh=max, yl=min(Y0,Y1), yh=max. Later corner writes update only the shadow registers and do not affect a running fill.
- FSM states:
  - IDLE -> FILL on a START write while BUSY=0.
    - Same edge: BUSY<=1, DONE<=0, cx<=xl, cy<=yl.
  - FILL: each cycle FB_WE=1, FB_ADDR={cy,cx}, FB_DATA=latched pixel value. Increment rule:
    - cx<xh: cx+1.
    - cx==xh, cy<yh: cx<=xl, cy+1.
    - cx==xh, cy==yh: last pixel; next state IDLE, BUSY<=0, DONE<=1, FB_WE<=0.
- Latency: START sampled at edge N gives the first FB_WE at edge N+1, and BUSY falls at edge N+1+P, where P=(xh-xl+1)*(yh-yl+1).
  - Degenerate single-pixel rectangle: P=1, exactly one write.
- Outputs are registered: no combinational path from the bus to FB_*.
- Boundary conditions:
  - START while BUSY=1: ignored; the fill continues unchanged.
  - Full-frame fill (0,0)-(159,119): exactly 19200 writes; no address ever exceeds x=159 or y=119.
  - Reset mid-fill: FB_WE and BUSY drop immediately (asynchronously); the fill is not resumed after reset.
  - DONE is sticky until the next accepted START or reset.
  - Addresses outside BASE..BASE+5 have no effect.

Decomposition:
- Shared package vga_pkg holds:
  - Register offsets (OFF_X0..OFF_STATUS).
  - State enum {IDLE, FILL}.
  - FRAME_W=160, FRAME_H=120.
  - FB address width 15, plus a helper that packs {y,x}.
- One natural sub-module: vga_rect_scanner.
  - Contains the cx/cy raster counters, the wrap logic, and the last-pixel flag.
  - The top level keeps the bus decode, clamping, shadow registers and tristate.

Test Plan:
- Corners (2,3)-(4,4), START data=1 -> FB_WE high 6 consecutive cycles; addresses in order (2,3),(3,3),(4,3),(2,4),(3,4),(4,4); FB_DATA=1; BUSY falls on the 7th edge after START; STATUS read returns 8'h02.
- Swapped corners X0=10,X1=8,Y0=5,Y1=5 -> 3 writes at x=8,9,10, y=5.
- X1=200, Y1=127 with X0=Y0=150/118 -> clamped; writes cover x 150..159, y 118..119 (20 writes); no FB_ADDR x>159.
- Second START mid-fill, plus a corner rewrite during the fill -> running fill is unchanged in count and addresses; the new corners are used only by the next START.
- RESET asserted on the 3rd pixel of a 100-pixel fill -> FB_WE=0 and BUSY=0 within the same cycle (asynchronously); STATUS reads 8'h00; no further writes.
- STATUS read with BUS_WE=0 -> BUS_DATA valid from the next cycle, Z one cycle after the address changes; a bus write to BASE+5 has no effect.
